// File: rtl/weight_fetch_sched_fc.sv
// weight_fetch_sched_fc
//   Address sequencer for the FC-layer weight ROM bank. There is one ROM per
//   array column. ROM i holds kernels i, i+COLS, i+2*COLS, ... and each
//   kernel is stored contiguously at fold*KLEN.
//   After a start, the block walks every column fold and every kernel
//   element. Between folds it inserts GAP_CYC idle cycles so the systolic
//   array can read out its partial sums. It also emits a valid/last stream
//   that lines up with the bank's 1-cycle read latency.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   start          launch request (honoured in IDLE only)
//   abort          synchronous abort back to IDLE
//   kernel_num     number of kernels (output neurons)
//   kernel_len     elements per kernel (KLEN)
//   act_ready      array accepts a weight beat this cycle
//   addr_r         element index within the kernel
//   base_addr      fold*KLEN, the ROM base address of the current fold
//   rom_select     fold*COLS
//   rd_valid       read issued to the bank (bank data_out_valid)
//   wt_valid       bank data valid (rd_valid delayed by one cycle)
//   wt_last_elem   with wt_valid: last element of a kernel
//   wt_last_fold   with wt_valid: the beat belongs to the final fold
//   fold_idx       current fold number
//   busy           sequence in progress
//   done           one-cycle completion pulse
//   cfg_err        one-cycle pulse when a start is rejected (zero size)
//
// GAP_CYC is counted in a 16-bit counter, so it must be at most 65536.

module weight_fetch_sched_fc #(
  parameter int COLS        = 4,
  parameter int ABS_ADDR_DW = 16,
  parameter int GAP_CYC     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [15:0]            kernel_num,
  input  logic [15:0]            kernel_len,
  input  logic                   act_ready,
  output logic [15:0]            addr_r,
  output logic [ABS_ADDR_DW-1:0] base_addr,
  output logic [15:0]            rom_select,
  output logic                   rd_valid,
  output logic                   wt_valid,
  output logic                   wt_last_elem,
  output logic                   wt_last_fold,
  output logic [15:0]            fold_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [15:0]            kn_reg, kn_next;
  logic [15:0]            kl_reg, kl_next;
  logic [15:0]            elem_reg, elem_next;
  logic [15:0]            fold_reg, fold_next;
  logic [ABS_ADDR_DW-1:0] base_reg, base_next;
  logic [15:0]            rsel_reg, rsel_next;
  logic [15:0]            gap_reg, gap_next;
  logic                   wt_valid_reg, wt_valid_next;
  logic                   wt_last_elem_reg, wt_last_elem_next;
  logic                   wt_last_fold_reg, wt_last_fold_next;
  logic                   cfg_err_reg, cfg_err_next;

  logic                   last_elem;
  logic                   last_fold;

  // Last-fold detection avoids a divider for ceil(kernel_num/COLS).
  // rom_select already equals fold*COLS, so the current fold is the final
  // one exactly when the next fold would begin at or beyond kernel_num.
  // The sum is done at 17 bits so that it cannot wrap.
  assign last_elem = (elem_reg == (kl_reg - 16'd1));
  assign last_fold = (({1'b0, rsel_reg} + 17'(COLS)) >= {1'b0, kn_reg});

  always_comb begin
    state_next   = state_reg;
    kn_next      = kn_reg;
    kl_next      = kl_reg;
    elem_next    = elem_reg;
    fold_next    = fold_reg;
    base_next    = base_reg;
    rsel_next    = rsel_reg;
    gap_next     = gap_reg;
    cfg_err_next = 1'b0;
    rd_valid     = 1'b0;
    done         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if ((kernel_num == 16'd0) || (kernel_len == 16'd0)) begin
            cfg_err_next = 1'b1;
          end else begin
            kn_next    = kernel_num;
            kl_next    = kernel_len;
            elem_next  = '0;
            fold_next  = '0;
            base_next  = '0;
            rsel_next  = '0;
            gap_next   = '0;
            state_next = RUN;
          end
        end
      end

      RUN: begin
        rd_valid = act_ready;
        if (act_ready) begin
          if (!last_elem) begin
            elem_next = elem_reg + 16'd1;
          end else begin
            elem_next = '0;
            fold_next = fold_reg + 16'd1;
            base_next = base_reg + ABS_ADDR_DW'(kl_reg);
            rsel_next = rsel_reg + 16'(COLS);
            if (last_fold) begin
              state_next = DRAIN;
            end else if (GAP_CYC > 0) begin
              gap_next   = '0;
              state_next = GAP;
            end
          end
        end
      end

      // The gap length is fixed: act_ready is ignored so that the array
      // always gets the same readout window.
      GAP: begin
        if (gap_reg == 16'(GAP_CYC - 1)) begin
          gap_next   = '0;
          state_next = RUN;
        end else begin
          gap_next = gap_reg + 16'd1;
        end
      end

      // The final beat's data leaves the bank in this cycle.
      DRAIN: begin
        done       = 1'b1;
        elem_next  = '0;
        fold_next  = '0;
        base_next  = '0;
        rsel_next  = '0;
        gap_next   = '0;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

    // Abort overrides everything, including a same-cycle start.
    if (abort) begin
      state_next   = IDLE;
      rd_valid     = 1'b0;
      done         = 1'b0;
      cfg_err_next = 1'b0;
      elem_next    = '0;
      fold_next    = '0;
      base_next    = '0;
      rsel_next    = '0;
      gap_next     = '0;
    end

    // These are captured in the issue cycle so that they emerge together
    // with the bank's read data one cycle later.
    wt_valid_next     = rd_valid;
    wt_last_elem_next = rd_valid & last_elem;
    wt_last_fold_next = rd_valid & last_fold;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      kn_reg           <= '0;
      kl_reg           <= '0;
      elem_reg         <= '0;
      fold_reg         <= '0;
      base_reg         <= '0;
      rsel_reg         <= '0;
      gap_reg          <= '0;
      wt_valid_reg     <= 1'b0;
      wt_last_elem_reg <= 1'b0;
      wt_last_fold_reg <= 1'b0;
      cfg_err_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      kn_reg           <= kn_next;
      kl_reg           <= kl_next;
      elem_reg         <= elem_next;
      fold_reg         <= fold_next;
      base_reg         <= base_next;
      rsel_reg         <= rsel_next;
      gap_reg          <= gap_next;
      wt_valid_reg     <= wt_valid_next;
      wt_last_elem_reg <= wt_last_elem_next;
      wt_last_fold_reg <= wt_last_fold_next;
      cfg_err_reg      <= cfg_err_next;
    end
  end

  assign addr_r       = elem_reg;
  assign base_addr    = base_reg;
  assign rom_select   = rsel_reg;
  assign fold_idx     = fold_reg;
  assign wt_valid     = wt_valid_reg;
  assign wt_last_elem = wt_last_elem_reg;
  assign wt_last_fold = wt_last_fold_reg;
  assign cfg_err      = cfg_err_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_weight_fetch_sched_fc.sv
// Testbench for weight_fetch_sched_fc.
// Inputs are driven 1 time unit after the rising edge.
// Outputs are sampled on the falling edge.
// run_job predicts the issue stream from a list of beats. Beat k is element
// k%KLEN of fold k/KLEN, and the fold's base address is fold*KLEN.
// A gap window of GAP cycles follows the last beat of every fold except the
// final one.

module tb_weight_fetch_sched_fc;
  localparam int COLS = 4;
  localparam int AW   = 16;
  localparam int GAP  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          act_ready = 1'b0;
  logic [15:0]   kernel_num = '0;
  logic [15:0]   kernel_len = '0;
  logic [15:0]   addr_r;
  logic [AW-1:0] base_addr;
  logic [15:0]   rom_select;
  logic          rd_valid, wt_valid, wt_last_elem, wt_last_fold;
  logic [15:0]   fold_idx;
  logic          busy, done, cfg_err;

  int checks = 0;
  int failures = 0;

  weight_fetch_sched_fc #(.COLS(COLS), .ABS_ADDR_DW(AW), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .kernel_num(kernel_num), .kernel_len(kernel_len), .act_ready(act_ready),
    .addr_r(addr_r), .base_addr(base_addr), .rom_select(rom_select),
    .rd_valid(rd_valid), .wt_valid(wt_valid), .wt_last_elem(wt_last_elem),
    .wt_last_fold(wt_last_fold), .fold_idx(fold_idx), .busy(busy),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // mode: 0 = act_ready always 1, 1 = act_ready low in cycles 2..4, 2 = random
  task automatic run_job(input int kn, input int kl, input int mode, input int abort_cyc,
                         input bit repulse, output int done_cyc, output int ndone,
                         output int beats);
    int  nfold, total, k, gap_left, last_issue, c;
    bit  prev_v, prev_le, prev_lf, exp_rd, exp_done, exp_busy, aborted, fin;
    nfold = (kn + COLS - 1) / COLS;
    total = nfold * kl;
    k = 0; gap_left = 0; last_issue = -10; c = 0;
    prev_v = 0; prev_le = 0; prev_lf = 0; aborted = 0; fin = 0;
    done_cyc = -1; ndone = 0; beats = 0;
    @(posedge clk); #1;
    start = 1'b1; kernel_num = 16'(kn); kernel_len = 16'(kl);
    act_ready = 1'($urandom_range(0, 1));
    while (!fin) begin
      @(posedge clk); #1;
      c++;
      start = 1'b0; abort = 1'b0;
      if (mode == 0) act_ready = 1'b1;
      else if (mode == 1) act_ready = !(c >= 2 && c <= 4);
      else act_ready = ($urandom_range(0, 99) >= 35);
      if (repulse && (c == 2 || c == 3)) begin
        start = 1'b1;
        kernel_num = 16'($urandom_range(1, 60));
        kernel_len = 16'($urandom_range(1, 9));
      end
      if (c == abort_cyc) abort = 1'b1;
      @(negedge clk);
      if (done) begin done_cyc = c; ndone++; end
      if (wt_valid) beats++;
      if (aborted) begin
        checks++;
        if ({busy, rd_valid, wt_valid, done} !== 4'b0 || addr_r !== 16'd0 ||
            base_addr !== '0 || rom_select !== 16'd0 || fold_idx !== 16'd0) begin
          failures++;
          $display("FAIL abort_idle c=%0d busy=%0b rd=%0b wt=%0b done=%0b addr=%0d base=%0d rom=%0d fold=%0d required all zero",
                   c, busy, rd_valid, wt_valid, done, addr_r, base_addr, rom_select, fold_idx);
        end
        fin = 1;
      end else if (c == abort_cyc) begin
        checks++;
        if (rd_valid !== 1'b0 || done !== 1'b0 || wt_valid !== prev_v) begin
          failures++;
          $display("FAIL abort_cycle c=%0d rd=%0b done=%0b wt=%0b required rd=0 done=0 wt=%0b",
                   c, rd_valid, done, wt_valid, prev_v);
        end
        aborted = 1;
      end else begin
        exp_rd   = (k < total) && (gap_left == 0) && act_ready;
        exp_done = (k == total) && (c == last_issue + 1);
        exp_busy = (k < total) || (c == last_issue + 1);
        checks++;
        if (rd_valid !== exp_rd) begin
          failures++;
          $display("FAIL rd_valid c=%0d got=%0b required=%0b", c, rd_valid, exp_rd);
        end
        if (k < total && gap_left == 0) begin
          checks++;
          if (addr_r !== 16'(k % kl) || fold_idx !== 16'(k / kl) ||
              base_addr !== AW'((k / kl) * kl) || rom_select !== 16'((k / kl) * COLS)) begin
            failures++;
            $display("FAIL issue_addr c=%0d beat=%0d got addr=%0d fold=%0d base=%0d rom=%0d required addr=%0d fold=%0d base=%0d rom=%0d",
                     c, k, addr_r, fold_idx, base_addr, rom_select,
                     k % kl, k / kl, (k / kl) * kl, (k / kl) * COLS);
          end
        end
        checks++;
        if (wt_valid !== prev_v || (prev_v && (wt_last_elem !== prev_le || wt_last_fold !== prev_lf))) begin
          failures++;
          $display("FAIL wt_stream c=%0d got v=%0b le=%0b lf=%0b required v=%0b le=%0b lf=%0b",
                   c, wt_valid, wt_last_elem, wt_last_fold, prev_v, prev_le, prev_lf);
        end
        checks++;
        if (done !== exp_done || busy !== exp_busy || cfg_err !== 1'b0) begin
          failures++;
          $display("FAIL done_busy c=%0d got done=%0b busy=%0b cfg_err=%0b required done=%0b busy=%0b cfg_err=0",
                   c, done, busy, cfg_err, exp_done, exp_busy);
        end
        if (k == total && c == last_issue + 2) begin
          checks++;
          if (addr_r !== 16'd0 || base_addr !== '0 || rom_select !== 16'd0 || fold_idx !== 16'd0) begin
            failures++;
            $display("FAIL idle_zero c=%0d addr=%0d base=%0d rom=%0d fold=%0d required 0",
                     c, addr_r, base_addr, rom_select, fold_idx);
          end
          fin = 1;
        end
        prev_v = exp_rd;
        if (gap_left > 0) begin
          gap_left--;
        end else if (exp_rd) begin
          prev_le = ((k % kl) == kl - 1);
          prev_lf = ((k / kl) == nfold - 1);
          k++;
          if (prev_le && !prev_lf) gap_left = GAP;
          if (k == total) last_issue = c;
        end
      end
      if (c > 3000 && !fin) begin
        failures++;
        $display("FAIL timeout c=%0d beats_issued=%0d required=%0d", c, k, total);
        fin = 1;
      end
    end
    start = 1'b0; abort = 1'b0; act_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rd_valid, wt_valid, wt_last_elem, wt_last_fold, busy, done, cfg_err} !== 7'b0 ||
        addr_r !== 16'd0 || base_addr !== '0 || rom_select !== 16'd0 || fold_idx !== 16'd0) begin
      failures++;
      $display("FAIL reset_state rd=%0b wt=%0b busy=%0b done=%0b cfg_err=%0b addr=%0d base=%0d rom=%0d fold=%0d required all zero",
               rd_valid, wt_valid, busy, done, cfg_err, addr_r, base_addr, rom_select, fold_idx);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int d, n, b;
    run_job(10, 3, 0, -1, 0, d, n, b);
    checks++;
    if (d != 14 || n != 1 || b != 9) begin
      failures++;
      $display("FAIL basic_seq done_cycle=%0d dones=%0d beats=%0d required 14/1/9", d, n, b);
    end
    $display("basic: kn=10 kl=3 done_cycle=%0d beats=%0d", d, b);
  endtask

  task automatic test_stall();
    int d, n, b;
    run_job(10, 3, 1, -1, 0, d, n, b);
    checks++;
    if (d != 17 || n != 1 || b != 9) begin
      failures++;
      $display("FAIL stall_seq done_cycle=%0d dones=%0d beats=%0d required 17/1/9", d, n, b);
    end
    $display("stall: kn=10 kl=3 done_cycle=%0d beats=%0d", d, b);
  endtask

  task automatic test_single_fold();
    int d, n, b;
    run_job(4, 1, 0, -1, 0, d, n, b);
    checks++;
    if (d != 2 || n != 1 || b != 1) begin
      failures++;
      $display("FAIL single_fold done_cycle=%0d dones=%0d beats=%0d required 2/1/1", d, n, b);
    end
    $display("single_fold: kn=4 kl=1 done_cycle=%0d beats=%0d", d, b);
  endtask

  task automatic test_cfg_err();
    for (int v = 0; v < 2; v++) begin
      @(posedge clk); #1;
      start = 1'b1; act_ready = 1'b1;
      kernel_num = (v == 0) ? 16'd5 : 16'd0;
      kernel_len = (v == 0) ? 16'd0 : 16'd3;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) begin
        failures++;
        $display("FAIL cfg_err_pulse v=%0d got cfg_err=%0b busy=%0b rd=%0b required 1/0/0", v, cfg_err, busy, rd_valid);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0) begin
        failures++;
        $display("FAIL cfg_err_clear v=%0d got cfg_err=%0b busy=%0b rd=%0b required 0/0/0", v, cfg_err, busy, rd_valid);
      end
      $display("cfg_err: kn=%0d kl=%0d rejected", kernel_num, kernel_len);
    end
    act_ready = 1'b0;
  endtask

  task automatic test_abort();
    int d, n, b;
    run_job(10, 3, 0, 7, 0, d, n, b);
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL abort_no_done dones=%0d required 0", n);
    end
    run_job(10, 3, 0, -1, 0, d, n, b);
    checks++;
    if (d != 14 || b != 9) begin
      failures++;
      $display("FAIL abort_restart done_cycle=%0d beats=%0d required 14/9", d, b);
    end
    $display("abort: restart done_cycle=%0d beats=%0d", d, b);
  endtask

  task automatic test_abort_start_same_cycle();
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; act_ready = 1'b1;
    kernel_num = 16'd8; kernel_len = 16'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL abort_beats_start busy=%0b rd=%0b cfg_err=%0b required 0/0/0", busy, rd_valid, cfg_err);
    end
    act_ready = 1'b0;
    $display("abort_start: nothing launched busy=%0b", busy);
  endtask

  task automatic test_repulse();
    int d, n, b;
    run_job(10, 3, 0, -1, 1, d, n, b);
    checks++;
    if (d != 14 || n != 1 || b != 9) begin
      failures++;
      $display("FAIL repulse done_cycle=%0d dones=%0d beats=%0d required 14/1/9", d, n, b);
    end
    $display("repulse: done_cycle=%0d dones=%0d beats=%0d", d, n, b);
  endtask

  task automatic test_reset_mid();
    int d, n, b;
    @(posedge clk); #1;
    start = 1'b1; act_ready = 1'b1; kernel_num = 16'd12; kernel_len = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_valid, wt_valid, busy, done} !== 4'b0 || addr_r !== 16'd0 || fold_idx !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid rd=%0b wt=%0b busy=%0b done=%0b addr=%0d fold=%0d required zero",
               rd_valid, wt_valid, busy, done, addr_r, fold_idx);
    end
    act_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_job(10, 3, 0, -1, 0, d, n, b);
    checks++;
    if (d != 14 || b != 9) begin
      failures++;
      $display("FAIL reset_restart done_cycle=%0d beats=%0d required 14/9", d, b);
    end
    $display("reset_mid: restart done_cycle=%0d", d);
  endtask

  task automatic test_random();
    int d, n, b, kn, kl;
    for (int j = 0; j < 10; j++) begin
      kn = $urandom_range(1, 25);
      kl = $urandom_range(1, 7);
      run_job(kn, kl, 2, -1, 0, d, n, b);
      checks++;
      if (n != 1 || b != ((kn + COLS - 1) / COLS) * kl) begin
        failures++;
        $display("FAIL random_job kn=%0d kl=%0d dones=%0d beats=%0d required 1/%0d",
                 kn, kl, n, b, ((kn + COLS - 1) / COLS) * kl);
      end
      $display("random: kn=%0d kl=%0d done_cycle=%0d beats=%0d", kn, kl, d, b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_single_fold();
    test_cfg_err();
    test_abort();
    test_abort_start_same_cycle();
    test_repulse();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
